hazard_ctrl: RTL and testbench

- Pipeline hazard controller; drives the stall/flush inputs of the IF/ID and ID/EX pipeline registers and the PC write-enable.
- Detects three conditions:
  - load-use data hazards between the instructions in ID and EX;
  - control redirects (taken branch or jump resolved in EX);
  - multi-cycle mult/div occupancy.
- A small FSM tracks mult/div busy time.
- Sits beside the decode stage.
- An ID/EX stall or flush inserts a bubble (register cleared); an IF/ID stall holds; an IF/ID flush clears.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/hazard_perf_cnt.sv | 13 +
 rtl/hazard_ctrl.sv | 69 ++++++
 tb/tb_hazard_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file width, hazard FSM states and the hardwired zero register
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;
  typedef enum logic {HZ_IDLE, HZ_BUSY} hz_state_e;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: 32-bit saturating event counter
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc,
  output logic [31:0] o_cnt
);
  logic [31:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 32'd1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and mult/div stall/flush control; HAZARD_PERF_CNT_EN adds event counters
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int REG_AW     = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_muldiv,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wr_addr,
  input  logic              ex_redirect,
  output logic              pc_stall,
  output logic              if2id_stall,
  output logic              if2id_flush,
  output logic              id2ex_stall,
  output logic              id2ex_flush,
  output logic              muldiv_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_load_use_cnt,
  output logic [31:0]       perf_muldiv_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);
  if (MULDIV_LAT < 2 || MULDIV_LAT > 16) begin : g_lat_chk
    $error("hazard_ctrl: MULDIV_LAT %0d outside 2..16", MULDIV_LAT);
  end
  hz_state_e   r_state, w_nxt_state;
  logic [3:0]  r_cnt, w_nxt_cnt;
  logic        w_load_use, w_issue, w_lu_stall, w_busy;
  assign w_load_use = ex_is_load && ex_wr_addr != REG_AW'(ZERO_REG) &&
                      ((id_uses_rs && id_rs_addr == ex_wr_addr) ||
                       (id_uses_rt && id_rt_addr == ex_wr_addr));
  assign w_busy     = r_state == HZ_BUSY;
  assign w_issue    = !w_busy && id_is_muldiv && !ex_redirect && !w_load_use;
  assign w_lu_stall = !w_busy && w_load_use && !ex_redirect;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= HZ_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  // Counter keeps running through redirects: the mult/div unit is unaffected by flushes
  always_comb begin
    w_nxt_state = w_busy ? (r_cnt == 4'd0 ? HZ_IDLE : HZ_BUSY) : (w_issue ? HZ_BUSY : HZ_IDLE);
    w_nxt_cnt   = w_busy ? (r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1) : (w_issue ? 4'(MULDIV_LAT - 2) : 4'd0);
  end
  always_comb begin
    pc_stall    = w_busy || w_lu_stall;
    if2id_stall = w_busy || w_lu_stall;
    id2ex_stall = w_busy || w_lu_stall;
    if2id_flush = ex_redirect;
    id2ex_flush = ex_redirect;
    muldiv_busy = w_busy;
  end
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_lu_cnt (.clk(clk), .rst_n(rst_n), .i_inc(w_lu_stall),  .o_cnt(perf_load_use_cnt));
  hazard_perf_cnt u_md_cnt (.clk(clk), .rst_n(rst_n), .i_inc(w_busy),      .o_cnt(perf_muldiv_stall_cnt));
  hazard_perf_cnt u_fl_cnt (.clk(clk), .rst_n(rst_n), .i_inc(ex_redirect), .o_cnt(perf_flush_cnt));
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (MULDIV_LAT = 4)
module tb_hazard_ctrl;
  logic       clk = 0;
  logic       rst_n = 0;
  logic [4:0] id_rs_addr = 0, id_rt_addr = 0, ex_wr_addr = 0;
  logic       id_uses_rs = 0, id_uses_rt = 0, id_is_muldiv = 0, ex_is_load = 0, ex_redirect = 0;
  logic       pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, muldiv_busy;
  logic [5:0] w_out;
  int         checks = 0, errors = 0;
  string      q_tag[$];
  logic [5:0] q_exp[$];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_load_use_cnt, perf_muldiv_stall_cnt, perf_flush_cnt;
`endif
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110100;
  localparam logic [5:0] BUSY  = 6'b110101;
  localparam logic [5:0] FLUSH = 6'b001010;
  localparam logic [5:0] BFL   = 6'b111111;
  hazard_ctrl #(.MULDIV_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .ex_is_load(ex_is_load),
    .ex_wr_addr(ex_wr_addr), .ex_redirect(ex_redirect),
    .pc_stall(pc_stall), .if2id_stall(if2id_stall), .if2id_flush(if2id_flush),
    .id2ex_stall(id2ex_stall), .id2ex_flush(id2ex_flush), .muldiv_busy(muldiv_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_load_use_cnt(perf_load_use_cnt), .perf_muldiv_stall_cnt(perf_muldiv_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign w_out = {pc_stall, if2id_stall, if2id_flush, id2ex_stall, id2ex_flush, muldiv_busy};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {id_rs_addr, id_rt_addr, ex_wr_addr} = '0;
    {id_uses_rs, id_uses_rt, id_is_muldiv, ex_is_load, ex_redirect} = '0;
  endtask
  task automatic load(input logic [4:0] wr, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt);
    ex_is_load = 1; ex_wr_addr = wr;
    id_rs_addr = rs; id_uses_rs = urs; id_rt_addr = rt; id_uses_rt = urt;
  endtask
  task automatic cyc(input string tag, input logic [5:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    @(negedge clk);
    check(q_tag.pop_front(), {26'b0, w_out}, {26'b0, q_exp.pop_front()});
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check("in_reset", {26'b0, w_out}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc("idle", NONE);
    load(8, 8, 1, 0, 0);           cyc("lu_rs", STALL);
    clr();                         cyc("lu_after", NONE);
    load(0, 0, 1, 0, 0);           cyc("lu_r0", NONE);
    load(5, 0, 0, 5, 1);           cyc("lu_rt", STALL);
    load(9, 9, 0, 9, 0);           cyc("lu_unused", NONE);
    clr(); id_is_muldiv = 1;       cyc("md_issue", NONE);
    clr();                         cyc("md_b1", BUSY);
                                   cyc("md_b2", BUSY);
                                   cyc("md_b3", BUSY);
                                   cyc("md_done", NONE);
    load(3, 3, 1, 0, 0); id_is_muldiv = 1; cyc("md_lu_blk", STALL);
    clr();                         cyc("md_lu_next", NONE);
    load(8, 8, 1, 0, 0); ex_redirect = 1; cyc("redir_lu", FLUSH);
    clr(); id_is_muldiv = 1; ex_redirect = 1; cyc("redir_md", FLUSH);
    clr();                         cyc("redir_md_next", NONE);
    id_is_muldiv = 1;              cyc("rb_issue", NONE);
    clr();                         cyc("rb_b1", BUSY);
    ex_redirect = 1;               cyc("rb_b2", BFL);
    clr();                         cyc("rb_b3", BUSY);
                                   cyc("rb_done", NONE);
    id_is_muldiv = 1;              cyc("rst_issue", NONE);
    clr();                         cyc("rst_b1", BUSY);
    #2 rst_n = 0;
    #1 check("rst_async", {26'b0, w_out}, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_lu", perf_load_use_cnt, 0);
    check("perf_md", perf_muldiv_stall_cnt, 0);
    check("perf_fl", perf_flush_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc("rst_idle", NONE);
                                   cyc("rst_idle2", NONE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
